// File: rtl/alu_pipe_hs.sv
// -----------------------------------------------------------------------------
// alu_pipe_hs
//   Handshaked 16-function ALU with a registered result holding stage and a
//   multi-cycle restoring signed divider. One operation is in flight at a time.
//
// Ports
//   CLK        rising-edge clock
//   RST        synchronous active-high reset
//   IN_VALID   A/B/ALU_FUN valid             IN_READY  block idle, can accept
//   A, B       signed operands (IN_WIDTH)    ALU_FUN   4-bit opcode
//   OUT_VALID  RESULT/flags valid            OUT_READY consumer takes result
//   RESULT     registered result (OUT_WIDTH)
//   CLASS      one-hot op class: [0] arith [1] logic [2] cmp [3] shift
//   CARRY_OUT  unsigned carry (add) / borrow (sub) out of bit W-1
//   DIV_ZERO   divide by zero
//   OVF        MIN/-1 divide overflow, or add/sub saturation
//
// Build option
//   ALU_SAT_EN  when defined, ops 0/1 saturate to the W-bit signed range and
//               raise OVF on saturation; otherwise they keep full precision.
// -----------------------------------------------------------------------------
module alu_pipe_hs #(
    parameter int IN_WIDTH  = 16,
    parameter int OUT_WIDTH = 2 * IN_WIDTH,
    parameter int CNT_WIDTH = 5
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 IN_VALID,
    output logic                 IN_READY,
    input  logic [IN_WIDTH-1:0]  A,
    input  logic [IN_WIDTH-1:0]  B,
    input  logic [3:0]           ALU_FUN,
    output logic                 OUT_VALID,
    input  logic                 OUT_READY,
    output logic [OUT_WIDTH-1:0] RESULT,
    output logic [3:0]           CLASS,
    output logic                 CARRY_OUT,
    output logic                 DIV_ZERO,
    output logic                 OVF
);

    localparam int W = IN_WIDTH;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_DIV  = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    localparam logic [W-1:0] MIN_W = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0] ONES_W = {W{1'b1}};

    localparam logic [3:0] CL_ARITH = 4'b0001;
    localparam logic [3:0] CL_LOGIC = 4'b0010;
    localparam logic [3:0] CL_CMP   = 4'b0100;
    localparam logic [3:0] CL_SHIFT = 4'b1000;

    function automatic logic [OUT_WIDTH-1:0] sext_w1(input logic [W:0] x);
        return {{(OUT_WIDTH-W-1){x[W]}}, x};
    endfunction

`ifdef ALU_SAT_EN
    function automatic logic [OUT_WIDTH-1:0] sext_w(input logic [W-1:0] x);
        return {{(OUT_WIDTH-W){x[W-1]}}, x};
    endfunction
`endif

    logic [1:0] state;

    assign IN_READY = (state == S_IDLE);

    // ---------------------------------------------------------------- datapath
    logic [W:0]              sum_ext, diff_ext;
    logic [W-1:0]            sum_w;
    logic signed [2*W-1:0]   prod;
    logic [W-1:0]            and_w, or_w, nand_w, nor_w;
    logic                    add_carry, sub_borrow;

    // W+1-bit sign-extended sum/difference hold the exact result.
    assign sum_ext    = {A[W-1], A} + {B[W-1], B};
    assign diff_ext   = {A[W-1], A} - {B[W-1], B};
    assign sum_w      = A + B;
    assign add_carry  = (sum_w < A);          // unsigned wrap means carry out
    assign sub_borrow = (A < B);              // unsigned borrow
    assign prod       = $signed(A) * $signed(B);
    assign and_w      = A & B;
    assign or_w       = A | B;
    assign nand_w     = ~and_w;
    assign nor_w      = ~or_w;

    logic [OUT_WIDTH-1:0] c_result;
    logic [3:0]           c_class;
    logic                 c_carry, c_dz, c_ovf;

    // Single-edge result for every op except a real divide (B != 0).
    always_comb begin
        c_result = '0;
        c_class  = CL_ARITH;
        c_carry  = 1'b0;
        c_dz     = 1'b0;
        c_ovf    = 1'b0;
        case (ALU_FUN)
            4'd0: begin
                c_carry = add_carry;
`ifdef ALU_SAT_EN
                if (sum_ext[W] != sum_ext[W-1]) begin
                    c_result = sext_w(sum_ext[W] ? MIN_W : ~MIN_W);
                    c_ovf    = 1'b1;
                end else begin
                    c_result = sext_w1(sum_ext);
                end
`else
                c_result = sext_w1(sum_ext);
`endif
            end
            4'd1: begin
                c_carry = sub_borrow;
`ifdef ALU_SAT_EN
                if (diff_ext[W] != diff_ext[W-1]) begin
                    c_result = sext_w(diff_ext[W] ? MIN_W : ~MIN_W);
                    c_ovf    = 1'b1;
                end else begin
                    c_result = sext_w1(diff_ext);
                end
`else
                c_result = sext_w1(diff_ext);
`endif
            end
            4'd2: c_result = OUT_WIDTH'(prod);
            4'd3: begin
                // Only reaches the output registers for B == 0.
                c_result = OUT_WIDTH'({A, ONES_W});
                c_dz     = 1'b1;
            end
            4'd4: begin c_class = CL_LOGIC; c_result = OUT_WIDTH'(and_w);  end
            4'd5: begin c_class = CL_LOGIC; c_result = OUT_WIDTH'(or_w);   end
            4'd6: begin c_class = CL_LOGIC; c_result = OUT_WIDTH'(nand_w); end
            4'd7: begin c_class = CL_LOGIC; c_result = OUT_WIDTH'(nor_w);  end
            4'd8: c_class = CL_CMP;
            4'd9: begin
                c_class  = CL_CMP;
                c_result = (A == B) ? OUT_WIDTH'(1) : '0;
            end
            4'd10: begin
                c_class  = CL_CMP;
                c_result = ($signed(A) > $signed(B)) ? OUT_WIDTH'(2) : '0;
            end
            4'd11: begin
                c_class  = CL_CMP;
                c_result = ($signed(A) < $signed(B)) ? OUT_WIDTH'(3) : '0;
            end
            4'd12: begin c_class = CL_SHIFT; c_result = OUT_WIDTH'({1'b0, A[W-1:1]}); end
            4'd13: begin c_class = CL_SHIFT; c_result = OUT_WIDTH'({A, 1'b0});        end
            4'd14: begin c_class = CL_SHIFT; c_result = OUT_WIDTH'({1'b0, B[W-1:1]}); end
            default: begin c_class = CL_SHIFT; c_result = OUT_WIDTH'({B, 1'b0}); end
        endcase
    end

    // ----------------------------------------------------------------- divider
    // Restoring division on magnitudes: dv_quo starts as |A| and shifts left,
    // feeding its MSB into the partial remainder while quotient bits enter
    // at the LSB. Signs are applied after the last step.
    logic [W-1:0]           dv_rem, dv_quo, dv_dsr;
    logic [CNT_WIDTH-1:0]   dv_cnt;
    logic                   dv_neg_q, dv_neg_r, dv_ovf;

    logic [W-1:0] mag_a, mag_b;
    assign mag_a = A[W-1] ? -A : A;   // MIN maps to 2^(W-1), still exact unsigned
    assign mag_b = B[W-1] ? -B : B;

    logic [W:0]   dv_shift, dv_trial;
    logic         dv_ok;
    logic [W-1:0] dv_rem_nx, dv_quo_nx, q_fin, r_fin;

    // Partial remainder stays below the divisor, so the shifted value fits
    // W+1 bits and the trial difference never wraps past bit W.
    assign dv_shift  = {dv_rem, dv_quo[W-1]};
    assign dv_trial  = dv_shift - {1'b0, dv_dsr};
    assign dv_ok     = ~dv_trial[W];
    assign dv_rem_nx = dv_ok ? dv_trial[W-1:0] : dv_shift[W-1:0];
    assign dv_quo_nx = {dv_quo[W-2:0], dv_ok};
    assign q_fin     = dv_neg_q ? -dv_quo_nx : dv_quo_nx;
    assign r_fin     = dv_neg_r ? -dv_rem_nx : dv_rem_nx;

    // --------------------------------------------------------------- control
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= S_IDLE;
            dv_cnt    <= '0;
            dv_rem    <= '0;
            dv_quo    <= '0;
            dv_dsr    <= '0;
            dv_neg_q  <= 1'b0;
            dv_neg_r  <= 1'b0;
            dv_ovf    <= 1'b0;
            RESULT    <= '0;
            CLASS     <= '0;
            CARRY_OUT <= 1'b0;
            DIV_ZERO  <= 1'b0;
            OVF       <= 1'b0;
            OUT_VALID <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (IN_VALID) begin
                        if (ALU_FUN == 4'd3 && B != '0) begin
                            dv_rem   <= '0;
                            dv_quo   <= mag_a;
                            dv_dsr   <= mag_b;
                            dv_cnt   <= '0;
                            dv_neg_q <= A[W-1] ^ B[W-1];
                            dv_neg_r <= A[W-1];
                            dv_ovf   <= (A == MIN_W) && (B == ONES_W);
                            state    <= S_DIV;
                        end else begin
                            RESULT    <= c_result;
                            CLASS     <= c_class;
                            CARRY_OUT <= c_carry;
                            DIV_ZERO  <= c_dz;
                            OVF       <= c_ovf;
                            OUT_VALID <= 1'b1;
                            state     <= S_HOLD;
                        end
                    end
                end
                S_DIV: begin
                    dv_rem <= dv_rem_nx;
                    dv_quo <= dv_quo_nx;
                    dv_cnt <= dv_cnt + 1'b1;
                    if (dv_cnt == CNT_WIDTH'(W - 1)) begin
                        // MIN/-1: magnitude quotient 2^(W-1) with positive
                        // sign already reads back as MIN in W bits.
                        RESULT    <= OUT_WIDTH'({r_fin, q_fin});
                        CLASS     <= CL_ARITH;
                        CARRY_OUT <= 1'b0;
                        DIV_ZERO  <= 1'b0;
                        OVF       <= dv_ovf;
                        OUT_VALID <= 1'b1;
                        state     <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (OUT_READY) begin
                        OUT_VALID <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_pipe_hs.sv
// -----------------------------------------------------------------------------
// tb_alu_pipe_hs
//   Directed bench for alu_pipe_hs (W=16): a table of vectors with hand-computed
//   results, flags and latency, plus sequences for stall, issue interval and
//   reset abort.
// -----------------------------------------------------------------------------
module tb_alu_pipe_hs;

    logic        CLK = 1'b0;
    logic        RST;
    logic        IN_VALID;
    logic        IN_READY;
    logic [15:0] A, B;
    logic [3:0]  ALU_FUN;
    logic        OUT_VALID;
    logic        OUT_READY;
    logic [31:0] RESULT;
    logic [3:0]  CLASS;
    logic        CARRY_OUT, DIV_ZERO, OVF;

    int checks = 0;
    int errors = 0;

    alu_pipe_hs #(.IN_WIDTH(16), .OUT_WIDTH(32), .CNT_WIDTH(5)) dut (
        .CLK(CLK), .RST(RST),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .A(A), .B(B), .ALU_FUN(ALU_FUN),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
        .RESULT(RESULT), .CLASS(CLASS),
        .CARRY_OUT(CARRY_OUT), .DIV_ZERO(DIV_ZERO), .OVF(OVF)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  op;
        logic [31:0] res;
        logic [3:0]  cls;
        logic        cy;
        logic        dz;
        logic        ov;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [15:0] a, input logic [15:0] b,
                                input logic [3:0] op, input logic [31:0] res,
                                input logic [3:0] cls, input logic cy,
                                input logic dz, input logic ov, input int lat);
        vec_t v;
        v.a = a; v.b = b; v.op = op; v.res = res; v.cls = cls;
        v.cy = cy; v.dz = dz; v.ov = ov; v.lat = lat;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        while (!IN_READY && n < 100) begin
            tick();
            n++;
        end
        if (!IN_READY) begin
            checks++;
            errors++;
            $display("FAIL %s ready_timeout actual=0 required=1", name);
        end
    endtask

    task automatic release_out(input string name);
        OUT_READY = 1'b1;
        tick();
        OUT_READY = 1'b0;
        chk({name, ".rel_ov"}, 64'(OUT_VALID), 64'd0);
        chk({name, ".rel_ir"}, 64'(IN_READY), 64'd1);
    endtask

    task automatic run_vec(input vec_t v, input string name);
        int lat;
        bit busy_ok;
        wait_ready(name);
        A = v.a; B = v.b; ALU_FUN = v.op; IN_VALID = 1'b1; OUT_READY = 1'b0;
        tick();
        IN_VALID = 1'b0;
        lat = 1;
        busy_ok = 1'b1;
        while (!OUT_VALID && lat < 64) begin
            if (IN_READY) busy_ok = 1'b0;
            tick();
            lat++;
        end
        chk({name, ".lat"},  64'(lat),       64'(v.lat));
        chk({name, ".busy"}, 64'(busy_ok),   64'd1);
        chk({name, ".res"},  64'(RESULT),    64'(v.res));
        chk({name, ".cls"},  64'(CLASS),     64'(v.cls));
        chk({name, ".cy"},   64'(CARRY_OUT), 64'(v.cy));
        chk({name, ".dz"},   64'(DIV_ZERO),  64'(v.dz));
        chk({name, ".ov"},   64'(OVF),       64'(v.ov));
        chk({name, ".hold_ir"}, 64'(IN_READY), 64'd0);
        release_out(name);
    endtask

    initial begin
        // a, b, op, result, class, carry, div0, ovf, latency
        vecs.push_back(mk(-16'sd4,  -16'sd6,  4'd0,  32'hFFFF_FFF6, 4'b0001, 1, 0, 0, 1));
        vecs.push_back(mk(16'd7,    16'd3,    4'd1,  32'h0000_0004, 4'b0001, 0, 0, 0, 1));
        vecs.push_back(mk(16'd3,    16'd7,    4'd1,  32'hFFFF_FFFC, 4'b0001, 1, 0, 0, 1));
        vecs.push_back(mk(-16'sd3,  16'd5,    4'd2,  32'hFFFF_FFF1, 4'b0001, 0, 0, 0, 1));
        vecs.push_back(mk(16'h7FFF, 16'h7FFF, 4'd2,  32'h3FFF_0001, 4'b0001, 0, 0, 0, 1));
        vecs.push_back(mk(-16'sd10, 16'd2,    4'd3,  32'h0000_FFFB, 4'b0001, 0, 0, 0, 17));
        vecs.push_back(mk(16'd7,    -16'sd2,  4'd3,  32'h0001_FFFD, 4'b0001, 0, 0, 0, 17));
        vecs.push_back(mk(-16'sd7,  16'd2,    4'd3,  32'hFFFF_FFFD, 4'b0001, 0, 0, 0, 17));
        vecs.push_back(mk(16'd5,    16'd0,    4'd3,  32'h0005_FFFF, 4'b0001, 0, 1, 0, 1));
        vecs.push_back(mk(16'h8000, 16'hFFFF, 4'd3,  32'h0000_8000, 4'b0001, 0, 0, 1, 17));
        vecs.push_back(mk(16'hF0F0, 16'h0FF0, 4'd4,  32'h0000_00F0, 4'b0010, 0, 0, 0, 1));
        vecs.push_back(mk(16'hF0F0, 16'h0FF0, 4'd5,  32'h0000_FFF0, 4'b0010, 0, 0, 0, 1));
        vecs.push_back(mk(16'hF0F0, 16'h0FF0, 4'd7,  32'h0000_000F, 4'b0010, 0, 0, 0, 1));
        vecs.push_back(mk(16'd5,    16'd5,    4'd8,  32'h0000_0000, 4'b0100, 0, 0, 0, 1));
        vecs.push_back(mk(16'd5,    16'd5,    4'd9,  32'h0000_0001, 4'b0100, 0, 0, 0, 1));
        vecs.push_back(mk(16'd5,    16'd6,    4'd9,  32'h0000_0000, 4'b0100, 0, 0, 0, 1));
        vecs.push_back(mk(16'hFFFF, 16'd1,    4'd10, 32'h0000_0000, 4'b0100, 0, 0, 0, 1));
        vecs.push_back(mk(16'd1,    16'hFFFF, 4'd10, 32'h0000_0002, 4'b0100, 0, 0, 0, 1));
        vecs.push_back(mk(16'd9,    16'd10,   4'd11, 32'h0000_0003, 4'b0100, 0, 0, 0, 1));
        vecs.push_back(mk(16'd10,   16'd0,    4'd13, 32'h0000_0014, 4'b1000, 0, 0, 0, 1));
        vecs.push_back(mk(16'h8001, 16'd0,    4'd12, 32'h0000_4000, 4'b1000, 0, 0, 0, 1));
        vecs.push_back(mk(16'h8001, 16'd0,    4'd13, 32'h0001_0002, 4'b1000, 0, 0, 0, 1));
        vecs.push_back(mk(16'd0,    16'h8001, 4'd14, 32'h0000_4000, 4'b1000, 0, 0, 0, 1));
        vecs.push_back(mk(16'd0,    16'hFFFF, 4'd15, 32'h0001_FFFE, 4'b1000, 0, 0, 0, 1));
`ifdef ALU_SAT_EN
        vecs.push_back(mk(16'h7FFF, 16'd1,    4'd0,  32'h0000_7FFF, 4'b0001, 0, 0, 1, 1));
        vecs.push_back(mk(16'h8000, 16'd1,    4'd1,  32'hFFFF_8000, 4'b0001, 0, 0, 1, 1));
`else
        vecs.push_back(mk(16'h7FFF, 16'd1,    4'd0,  32'h0000_8000, 4'b0001, 0, 0, 0, 1));
        vecs.push_back(mk(16'h8000, 16'd1,    4'd1,  32'hFFFF_7FFF, 4'b0001, 0, 0, 0, 1));
`endif

        RST = 1'b1; IN_VALID = 1'b0; OUT_READY = 1'b0;
        A = '0; B = '0; ALU_FUN = '0;
        tick();
        tick();
        chk("rst.ov",  64'(OUT_VALID), 64'd0);
        chk("rst.res", 64'(RESULT),    64'd0);
        chk("rst.cls", 64'(CLASS),     64'd0);
        chk("rst.flg", 64'({CARRY_OUT, DIV_ZERO, OVF}), 64'd0);
        RST = 1'b0;
        tick();
        chk("rst.ir",  64'(IN_READY),  64'd1);

        foreach (vecs[i]) run_vec(vecs[i], $sformatf("v%0d", i));

        // Stall in HOLD: NAND 11,4 held for 5 cycles.
        wait_ready("stall");
        A = 16'd11; B = 16'd4; ALU_FUN = 4'd6; IN_VALID = 1'b1;
        tick();
        IN_VALID = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("stall%0d.res", k), 64'(RESULT),    64'h0000_FFFF);
            chk($sformatf("stall%0d.ov", k),  64'(OUT_VALID), 64'd1);
            chk($sformatf("stall%0d.ir", k),  64'(IN_READY),  64'd0);
            tick();
        end
        chk("stall.cls", 64'(CLASS), 64'b0010);
        release_out("stall");

        // Input offered on the HOLD release edge must wait one more edge.
        wait_ready("issue");
        A = 16'd1; B = 16'd2; ALU_FUN = 4'd0; IN_VALID = 1'b1;
        tick();
        A = 16'd3; B = 16'd4; OUT_READY = 1'b1;
        tick();
        OUT_READY = 1'b0;
        chk("issue.ov0", 64'(OUT_VALID), 64'd0);
        chk("issue.ir0", 64'(IN_READY),  64'd1);
        tick();
        IN_VALID = 1'b0;
        chk("issue.ov1", 64'(OUT_VALID), 64'd1);
        chk("issue.res", 64'(RESULT),    64'd7);
        release_out("issue");

        // Reset in the middle of a divide aborts it.
        wait_ready("abort");
        A = 16'd100; B = 16'd3; ALU_FUN = 4'd3; IN_VALID = 1'b1;
        tick();
        IN_VALID = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        chk("abort.busy", 64'(IN_READY), 64'd0);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        chk("abort.ov",  64'(OUT_VALID), 64'd0);
        chk("abort.res", 64'(RESULT),    64'd0);
        chk("abort.ir",  64'(IN_READY),  64'd1);
        chk("abort.cls", 64'(CLASS),     64'd0);

        // Recovery: same divide runs to completion (100/3 = 33 r 1).
        run_vec(mk(16'd100, 16'd3, 4'd3, 32'h0001_0021, 4'b0001, 0, 0, 0, 17), "after_abort");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
